// File: rtl/display_scan_controller.sv
// display_scan_controller: four-digit multiplexed BCD scanner with dead-time blanking,
// optional leading-zero suppression and frame-aligned commit of newly loaded values.
module display_scan_controller #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic        blank_lz,
    output logic        ready,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic [1:0]  sel
);
    localparam int PW = $clog2(CLK_DIV);
    typedef enum logic {BLANK, SHOW} state_t;
    state_t        state, state_nxt;
    logic [PW-1:0] phase, phase_nxt;
    logic [15:0]   active, shadow, active_nxt;
    logic [1:0]    sel_nxt;
    logic [3:0]    supp, nib;
    logic          pending, wrap, commit, lit;
    // Outputs are registered from next-cycle state so they line up with phase/sel.
    always_comb begin
        wrap       = phase == PW'(CLK_DIV - 1);
        phase_nxt  = wrap ? '0 : phase + PW'(1);
        sel_nxt    = wrap ? sel + 2'd1 : sel;
        commit     = wrap && sel == 2'd3 && pending;
        active_nxt = commit ? shadow : active;
        state_nxt  = wrap ? BLANK : phase_nxt == PW'(BLANK_CYCLES) ? SHOW : state;
        supp[0]    = 1'b0;
        supp[1]    = blank_lz && active_nxt[15:4] == '0;
        supp[2]    = blank_lz && active_nxt[15:8] == '0;
        supp[3]    = blank_lz && active_nxt[15:12] == '0;
        nib        = active_nxt[{sel_nxt, 2'b00} +: 4];
        lit        = state_nxt == SHOW && !supp[sel_nxt];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BLANK;
            phase   <= '0;
            sel     <= '0;
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            ready   <= 1'b1;
            an      <= 4'b1111;
            bcd_out <= 4'hF;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            sel     <= sel_nxt;
            active  <= active_nxt;
            an      <= lit ? ~(4'b0001 << sel_nxt) : 4'b1111;
            bcd_out <= lit ? nib : 4'hF;
            if (load && ready) begin
                shadow  <= digits_in;
                pending <= 1'b1;
                ready   <= 1'b0;
            end else if (commit) begin
                pending <= 1'b0;
                ready   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: directed stimulus with a cycle-stamped expectation
// queue checked by an independent negedge monitor.
module tb_display_scan_controller;
    logic        clk = 0, reset = 1, load = 0, blank_lz = 0;
    logic [15:0] digits_in = '0;
    logic        ready;
    logic [3:0]  bcd_out, an;
    logic [1:0]  sel;
    int          kc = 0, n_cmp = 0, n_bad = 0;

    typedef struct {
        int         k;
        string      name;
        logic [3:0] an;
        logic [3:0] bcd;
        logic [1:0] sel;
        logic       rdy;
    } exp_t;
    exp_t q[$];

    display_scan_controller #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .load(load), .digits_in(digits_in),
        .blank_lz(blank_lz), .ready(ready), .bcd_out(bcd_out), .an(an), .sel(sel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) kc <= reset ? 0 : kc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].k <= kc) begin
            n_cmp++;
            if (q[0].k < kc) begin
                n_bad++;
                $display("FAIL %s k=%0d: check slot missed at k=%0d", q[0].name, q[0].k, kc);
            end else if (an !== q[0].an || bcd_out !== q[0].bcd || sel !== q[0].sel || ready !== q[0].rdy) begin
                n_bad++;
                $display("FAIL %s k=%0d: got an=%b bcd=%h sel=%0d ready=%b, expected an=%b bcd=%h sel=%0d ready=%b",
                         q[0].name, kc, an, bcd_out, sel, ready, q[0].an, q[0].bcd, q[0].sel, q[0].rdy);
            end
            void'(q.pop_front());
        end
    end

    task automatic exp(input int k, input string name, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] s, input logic r);
        exp_t e;
        int   i = 0;
        e = '{k, name, a, b, s, r};
        while (i < q.size() && q[i].k <= k) i++;
        q.insert(i, e);
    endtask

    task automatic to_k(input int n);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (kc == n) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL to_k: cycle %0d never reached, kc=%0d", n, kc);
    endtask

    task automatic do_load(input int n, input logic [15:0] v);
        to_k(n);
        load = 1;
        digits_in = v;
        to_k(n + 1);
        load = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        exp(0, "reset", 4'b1111, 4'hF, 0, 1);
        exp(1, "reset_blank", 4'b1111, 4'hF, 0, 1);
        exp(2, "first_show", 4'b1110, 4'h0, 0, 1);
        exp(5, "ready_before_load", 4'b1110, 4'h0, 0, 1);
        exp(6, "ready_fall", 4'b1110, 4'h0, 0, 0);
        exp(8, "slot1_blank", 4'b1111, 4'hF, 1, 0);
        exp(10, "load_ignored", 4'b1101, 4'h0, 1, 0);
        exp(31, "pre_commit", 4'b0111, 4'h0, 3, 0);
        exp(32, "commit_ready", 4'b1111, 4'hF, 0, 1);
        exp(34, "commit_0001", 4'b1110, 4'h1, 0, 1);
        exp(42, "digit1_0001", 4'b1101, 4'h0, 1, 0);
        exp(58, "digit3_0001", 4'b0111, 4'h0, 3, 0);
        do_load(5, 16'h0001);
        do_load(10, 16'h9999);
        // 1234 basic scan, committed at the k=63 wrap
        exp(41, "load1234_ready", 4'b1111, 4'hF, 1, 0);
        exp(64, "scan_s0_blank", 4'b1111, 4'hF, 0, 1);
        exp(66, "scan_s0_first", 4'b1110, 4'h4, 0, 1);
        exp(71, "scan_s0_last", 4'b1110, 4'h4, 0, 1);
        exp(72, "scan_s1_blank0", 4'b1111, 4'hF, 1, 1);
        exp(73, "scan_s1_blank1", 4'b1111, 4'hF, 1, 1);
        exp(74, "scan_s1", 4'b1101, 4'h3, 1, 1);
        exp(82, "scan_s2", 4'b1011, 4'h2, 2, 1);
        exp(90, "scan_s3", 4'b0111, 4'h1, 3, 1);
        exp(95, "scan_s3_last", 4'b0111, 4'h1, 3, 1);
        do_load(40, 16'h1234);
        // 0070 leading-zero blanking
        exp(97, "load0070_ready", 4'b1111, 4'hF, 0, 0);
        exp(106, "lz_no_effect_1234", 4'b1101, 4'h3, 1, 0);
        exp(130, "lz_d0", 4'b1110, 4'h0, 0, 1);
        exp(138, "lz_d1", 4'b1101, 4'h7, 1, 1);
        exp(146, "lz_d2_blank", 4'b1111, 4'hF, 2, 1);
        exp(154, "lz_d3_blank", 4'b1111, 4'hF, 3, 1);
        exp(162, "nolz_d0", 4'b1110, 4'h0, 0, 1);
        exp(170, "nolz_d1", 4'b1101, 4'h7, 1, 1);
        exp(178, "nolz_d2", 4'b1011, 4'h0, 2, 1);
        exp(186, "nolz_d3", 4'b0111, 4'h0, 3, 1);
        exp(190, "lz_before_toggle", 4'b0111, 4'h0, 3, 1);
        exp(191, "lz_next_cycle", 4'b1111, 4'hF, 3, 1);
        do_load(96, 16'h0070);
        to_k(100);
        blank_lz = 1;
        to_k(159);
        blank_lz = 0;
        to_k(190);
        blank_lz = 1;
        // all-zero and non-BCD nibble
        exp(193, "load0000_ready", 4'b1111, 4'hF, 0, 0);
        exp(226, "zero_d0", 4'b1110, 4'h0, 0, 1);
        exp(234, "zero_d1", 4'b1111, 4'hF, 1, 1);
        exp(242, "zero_d2", 4'b1111, 4'hF, 2, 1);
        exp(250, "zero_d3", 4'b1111, 4'hF, 3, 1);
        exp(290, "a0_d0", 4'b1110, 4'h0, 0, 1);
        exp(298, "a0_d1", 4'b1101, 4'hA, 1, 1);
        exp(306, "a0_d2", 4'b1111, 4'hF, 2, 1);
        exp(314, "a0_d3", 4'b1111, 4'hF, 3, 1);
        do_load(192, 16'h0000);
        do_load(256, 16'h00A0);
        // reset while 5555 is pending in slot 2
        exp(337, "pending_s2", 4'b1111, 4'hF, 2, 0);
        exp(338, "pending_s2_show", 4'b1111, 4'hF, 2, 0);
        do_load(320, 16'h5555);
        to_k(338);
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        exp(0, "midrst", 4'b1111, 4'hF, 0, 1);
        exp(2, "midrst_d0", 4'b1110, 4'h0, 0, 1);
        exp(10, "midrst_d1", 4'b1111, 4'hF, 1, 1);
        exp(31, "midrst_s3", 4'b1111, 4'hF, 3, 1);
        exp(34, "midrst_discard", 4'b1110, 4'h0, 0, 1);
        exp(42, "midrst_d1_again", 4'b1111, 4'hF, 1, 1);
        for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        while (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s k=%0d: never checked, kc=%0d", q[0].name, q[0].k, kc);
            void'(q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
